pc_return_stack: RTL

//  Program-counter stage feeding instruction fetch of the single-cycle core. Each cycle it

---
 rtl/pc_return_stack_if.sv | 28 ++
 rtl/pc_return_stack.sv | 97 +++++++++
 2 files changed

// File: rtl/pc_return_stack_if.sv
// Control-unit <-> PC stage bundle: strobes and target in, PC, occupancy and error flags out.
interface pc_return_stack_if #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  localparam int DEPTH_W = $clog2(DEPTH + 1);

  logic               en;
  logic               jmp;
  logic               ret;
  logic [ADDR_W-1:0]  target;
  logic [ADDR_W-1:0]  pc;
  logic [DEPTH_W-1:0] depth;
  logic               stk_full;
  logic               stk_empty;
  logic               ovf_err;
  logic               unf_err;

  modport master (
    output en, jmp, ret, target,
    input  pc, depth, stk_full, stk_empty, ovf_err, unf_err
  );

  modport slave (
    input  en, jmp, ret, target,
    output pc, depth, stk_full, stk_empty, ovf_err, unf_err
  );
endinterface

// File: rtl/pc_return_stack.sv
// PC stage with a hardware return-address stack: jmp pushes pc+1 and jumps, ret pops.
// Occupancy and sticky overflow/underflow flags are reported alongside the PC.
module pc_return_stack #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  parameter int RST_PC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_return_stack_if.slave bus
);
  localparam int DEPTH_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_err_q, ovf_err_d;
  logic               unf_err_q, unf_err_d;
  logic [ADDR_W-1:0]  stack_q [DEPTH];
  logic [ADDR_W-1:0]  stack_d [DEPTH];

  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  stack_top;
  logic               full;
  logic               empty;
  logic               push;

  assign pc_inc = pc_q + 1'b1;
  assign full   = (depth_q == DEPTH_W'(DEPTH));
  assign empty  = (depth_q == '0);

  always_comb begin
    pc_d      = pc_q;
    depth_d   = depth_q;
    ovf_err_d = ovf_err_q;
    unf_err_d = unf_err_q;
    push      = 1'b0;
    stack_top = '0;

    // Top-of-stack lives at depth-1; compare-based mux keeps index widths exact.
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == DEPTH_W'(i + 1)) stack_top = stack_q[i];
    end

    if (bus.en) begin
      if (bus.jmp) begin
        pc_d = bus.target;
        if (full) begin
          ovf_err_d = 1'b1;
        end else begin
          push    = 1'b1;
          depth_d = depth_q + 1'b1;
        end
      end else if (bus.ret) begin
        if (empty) begin
          unf_err_d = 1'b1;
          pc_d      = pc_inc;
        end else begin
          pc_d    = stack_top;
          depth_d = depth_q - 1'b1;
        end
      end else begin
        pc_d = pc_inc;
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      stack_d[i] = stack_q[i];
      if (push && (depth_q == DEPTH_W'(i))) stack_d[i] = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= ADDR_W'(RST_PC);
      depth_q   <= '0;
      ovf_err_q <= 1'b0;
      unf_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      depth_q   <= depth_d;
      ovf_err_q <= ovf_err_d;
      unf_err_q <= unf_err_d;
    end
  end

  // Entries above depth are dead after reset, so the array needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
  end

  assign bus.pc        = pc_q;
  assign bus.depth     = depth_q;
  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
  assign bus.ovf_err   = ovf_err_q;
  assign bus.unf_err   = unf_err_q;
endmodule
